// File: rtl/wb_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_timer_pkg
// Brief    : Shared register map, CTRL layout and byte-merge helper for the
//            multi-channel Wishbone timer.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
package wb_timer_pkg;

  // adr[7] splits channel space (0) from global space (1)
  localparam int c_gsel_bit = 7;

  // Per-channel register select, taken from adr[3:2]
  typedef enum logic [1:0] {
    REG_CTRL = 2'b00,
    REG_CMP  = 2'b01,
    REG_CNT  = 2'b10,
    REG_STAT = 2'b11
  } chan_reg_e;

  // Byte offsets of the global registers
  localparam logic [7:0] c_off_prescale = 8'h80;
  localparam logic [7:0] c_off_irqsum   = 8'h84;

  // CTRL bit positions
  localparam int c_ctrl_en = 0;
  localparam int c_ctrl_ar = 1;
  localparam int c_ctrl_ie = 2;

  typedef struct packed {
    logic ie;
    logic ar;
    logic en;
  } ctrl_t;

  // Replace each byte lane of old_v whose select bit is set
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timer_chan.sv
`default_nettype none
// ============================================================================
// Module   : wb_timer_chan
// Brief    : One timer channel: CTRL/COMPARE/COUNTER/FLAG registers, tick
//            driven up-count with one-shot or auto-reload match handling and a
//            registered level interrupt.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module wb_timer_chan
  import wb_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             ctrl_we_i,
  input  logic             cmp_we_i,
  input  logic             cnt_we_i,
  input  logic             stat_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [2:0]       ctrl_o,
  output logic [CNT_W-1:0] compare_o,
  output logic [CNT_W-1:0] counter_o,
  output logic             flag_o,
  output logic             intr_o
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             intr_q;

  logic [31:0]      w_cmp_wr;
  logic [31:0]      w_cnt_wr;
  logic             w_ctrl_load;
  logic             w_cnt_load;
  logic             w_flag_set;
  logic             w_flag_clr;

  assign w_cmp_wr    = be_merge(32'(cmp_q), wb_dat_i, wb_sel_i);
  assign w_cnt_wr    = be_merge(32'(cnt_q), wb_dat_i, wb_sel_i);
  assign w_ctrl_load = ctrl_we_i & wb_sel_i[0];
  assign w_cnt_load  = cnt_we_i & (|wb_sel_i);
  assign w_flag_clr  = stat_we_i & wb_sel_i[0] & wb_dat_i[0];

  // Next-state: a software CTRL or COUNTER load pre-empts the tick update
  always_comb begin
    ctrl_d     = ctrl_q;
    cmp_d      = cmp_q;
    cnt_d      = cnt_q;
    flag_d     = flag_q;
    w_flag_set = 1'b0;

    if (cmp_we_i) cmp_d = w_cmp_wr[CNT_W-1:0];

    if (w_ctrl_load) begin
      ctrl_d.en = wb_dat_i[c_ctrl_en];
      ctrl_d.ar = wb_dat_i[c_ctrl_ar];
      ctrl_d.ie = wb_dat_i[c_ctrl_ie];
    end else if (w_cnt_load) begin
      cnt_d = w_cnt_wr[CNT_W-1:0];
    end else if (tick_i && ctrl_q.en) begin
      if (cnt_q == cmp_q) begin
        w_flag_set = 1'b1;
        if (ctrl_q.ar) cnt_d = '0;
        else           ctrl_d.en = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A match in the same cycle as a software clear keeps the flag set
    if (w_flag_set)      flag_d = 1'b1;
    else if (w_flag_clr) flag_d = 1'b0;
  end

  // Channel state registers; interrupt lags FLAG/IE by one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      cmp_q  <= '0;
      cnt_q  <= '0;
      flag_q <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      cmp_q  <= cmp_d;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      intr_q <= flag_q & ctrl_q.ie;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign compare_o = cmp_q;
  assign counter_o = cnt_q;
  assign flag_o    = flag_q;
  assign intr_o    = intr_q;

endmodule
`default_nettype wire

// File: rtl/wb_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : wb_timer_multi
// Brief    : Multi-channel Wishbone timer slave. Bus decode, single-cycle ack
//            pulse, registered read mux and the shared prescaler live here;
//            each channel is a wb_timer_chan instance.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module wb_timer_multi
  import wb_timer_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int CNT_W      = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic [NUM_TIMERS-1:0] intr
);

  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [PRESCALE_W-1:0] pc_q, pc_d;

  logic                  w_acc;
  logic                  w_wr;
  logic                  w_glb;
  logic                  w_chan_space;
  logic [1:0]            w_ch;
  chan_reg_e             w_reg;
  logic                  w_pre_wr;
  logic                  w_tick;
  logic [31:0]           w_pre_merge;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  logic [NUM_TIMERS-1:0][2:0]       w_ctrl;
  logic [NUM_TIMERS-1:0][CNT_W-1:0] w_cmp;
  logic [NUM_TIMERS-1:0][CNT_W-1:0] w_cnt;
  logic [NUM_TIMERS-1:0]            w_flag;
  logic [NUM_TIMERS-1:0]            w_intr;

  // A request is accepted only while ack is low, so acks are at most every
  // other cycle and a held strobe cannot be acknowledged twice
  assign w_acc        = wb_cyc_i & wb_stb_i & ~ack_q;
  assign w_wr         = w_acc & wb_we_i;
  assign w_glb        = wb_adr_i[c_gsel_bit];
  assign w_chan_space = ~w_glb & ~wb_adr_i[6];
  assign w_ch         = wb_adr_i[5:4];
  assign w_reg        = chan_reg_e'(wb_adr_i[3:2]);
  assign w_pre_wr     = w_wr & (wb_adr_i[7:2] == c_off_prescale[7:2]);
  assign w_tick       = (pc_q == pre_q);
  assign w_pre_merge  = be_merge(32'(pre_q), wb_dat_i, wb_sel_i);
  assign w_unused     = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

  for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_chan
    logic w_hit;
    assign w_hit = w_wr & w_chan_space & (w_ch == 2'(gi));

    wb_timer_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tick_i    (w_tick),
      .ctrl_we_i (w_hit & (w_reg == REG_CTRL)),
      .cmp_we_i  (w_hit & (w_reg == REG_CMP)),
      .cnt_we_i  (w_hit & (w_reg == REG_CNT)),
      .stat_we_i (w_hit & (w_reg == REG_STAT)),
      .wb_sel_i  (wb_sel_i),
      .wb_dat_i  (wb_dat_i),
      .ctrl_o    (w_ctrl[gi]),
      .compare_o (w_cmp[gi]),
      .counter_o (w_cnt[gi]),
      .flag_o    (w_flag[gi]),
      .intr_o    (w_intr[gi])
    );
  end

  // Read mux: unmapped offsets and absent channels return zero
  always_comb begin
    w_rdata = '0;
    if (w_glb) begin
      if (wb_adr_i[6:2] == c_off_prescale[6:2])    w_rdata[PRESCALE_W-1:0] = pre_q;
      else if (wb_adr_i[6:2] == c_off_irqsum[6:2]) w_rdata[NUM_TIMERS-1:0] = w_intr;
    end else if (w_chan_space) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (w_ch == 2'(i)) begin
          case (w_reg)
            REG_CTRL: w_rdata[2:0]       = w_ctrl[i];
            REG_CMP:  w_rdata[CNT_W-1:0] = w_cmp[i];
            REG_CNT:  w_rdata[CNT_W-1:0] = w_cnt[i];
            default:  w_rdata[0]         = w_flag[i];
          endcase
        end
      end
    end
  end

  // Ack, read data and prescaler next-state; a PRESCALE write restarts the phase
  always_comb begin
    ack_d = w_acc;
    dat_d = (w_acc & ~wb_we_i) ? w_rdata : '0;
    pre_d = pre_q;
    pc_d  = w_tick ? '0 : pc_q + 1'b1;
    if (w_pre_wr) begin
      pre_d = w_pre_merge[PRESCALE_W-1:0];
      pc_d  = '0;
    end
  end

  // Bus-side and prescaler registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      pre_q <= '0;
      pc_q  <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      pre_q <= pre_d;
      pc_q  <= pc_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr     = w_intr;

endmodule
`default_nettype wire

// File: tb/tb_wb_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_timer_multi
// Brief    : Scoreboard bench for wb_timer_multi. A reference model steps the
//            register-level rules each clock and queues the expected bus
//            response; a monitor pops and compares on every ack and checks
//            the interrupt vector every cycle.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module tb_wb_timer_multi;

  localparam int NT = 2;

  logic          clk, rst;
  logic [31:0]   adr, dat_w, dat_r;
  logic [3:0]    sel;
  logic          we, stb, cyc, ack;
  logic [NT-1:0] intr;

  int n_checks;
  int n_errors;

  wb_timer_multi #(
    .NUM_TIMERS(NT),
    .CNT_W     (32),
    .PRESCALE_W(16)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .wb_adr_i(adr),
    .wb_dat_i(dat_w),
    .wb_dat_o(dat_r),
    .wb_sel_i(sel),
    .wb_we_i (we),
    .wb_stb_i(stb),
    .wb_cyc_i(cyc),
    .wb_ack_o(ack),
    .intr    (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit          rd;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  logic          m_ack;
  logic [15:0]   m_pc, m_pre;
  logic [31:0]   m_cmp[NT];
  logic [31:0]   m_cnt[NT];
  logic [NT-1:0] m_en, m_ar, m_ie, m_flag, m_intr;

  logic       t_acc, t_wr, t_tick;
  logic [7:0] t_off;
  assign t_acc  = cyc & stb & ~m_ack;
  assign t_wr   = t_acc & we;
  assign t_off  = adr[7:0] & 8'hFC;
  assign t_tick = (m_pc == m_pre);

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic bit hit(input int i, input int r);
    return t_wr && (t_off == 8'(i*16 + r*4));
  endfunction

  function automatic logic [31:0] mread(input logic [7:0] off);
    int ch, r;
    if (off == 8'h80) return 32'(m_pre);
    if (off == 8'h84) return 32'(m_intr);
    if (off >= 8'h40) return 32'h0;
    ch = int'(off) / 16;
    r  = (int'(off) % 16) / 4;
    if (ch >= NT) return 32'h0;
    case (r)
      0:       return {29'h0, m_ie[ch], m_ar[ch], m_en[ch]};
      1:       return m_cmp[ch];
      2:       return m_cnt[ch];
      default: return {31'h0, m_flag[ch]};
    endcase
  endfunction

  function automatic exp_t mk(input bit rd, input logic [31:0] d);
    exp_t e;
    e.rd = rd;
    e.d  = d;
    return e;
  endfunction

  // Model step: all reads see pre-edge state, later assignments take priority
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack  <= 1'b0;
      m_pc   <= '0;
      m_pre  <= '0;
      m_en   <= '0;
      m_ar   <= '0;
      m_ie   <= '0;
      m_flag <= '0;
      m_intr <= '0;
      for (int i = 0; i < NT; i++) begin
        m_cmp[i] <= '0;
        m_cnt[i] <= '0;
      end
      sb.delete();
    end else begin
      m_ack <= t_acc;
      if (t_acc) sb.push_back(mk(!we, we ? 32'h0 : mread(t_off)));
      m_pc <= t_tick ? 16'h0 : m_pc + 16'h1;
      if (t_wr && t_off == 8'h80) begin
        m_pre <= 16'(merge(32'(m_pre), dat_w, sel));
        m_pc  <= 16'h0;
      end
      for (int i = 0; i < NT; i++) begin
        m_intr[i] <= m_flag[i] & m_ie[i];
        if (hit(i, 3) && sel[0] && dat_w[0]) m_flag[i] <= 1'b0;
        if (hit(i, 0) && sel[0]) begin
          m_en[i] <= dat_w[0];
          m_ar[i] <= dat_w[1];
          m_ie[i] <= dat_w[2];
        end else if (hit(i, 2) && sel != 4'h0) begin
          m_cnt[i] <= merge(m_cnt[i], dat_w, sel);
        end else if (t_tick && m_en[i]) begin
          if (m_cnt[i] == m_cmp[i]) begin
            m_flag[i] <= 1'b1;
            if (m_ar[i]) m_cnt[i] <= 32'h0;
            else         m_en[i]  <= 1'b0;
          end else begin
            m_cnt[i] <= m_cnt[i] + 32'h1;
          end
        end
        if (hit(i, 1)) m_cmp[i] <= merge(m_cmp[i], dat_w, sel);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (intr !== m_intr) begin
        n_errors++;
        $display("FAIL intr_vec: got %b expected %b at %0t", intr, m_intr, $time);
      end
      if (ack) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_ack: ack with no pending access at %0t", $time);
        end else begin
          if (sb[0].rd) begin
            n_checks++;
            if (dat_r !== sb[0].d) begin
              n_errors++;
              $display("FAIL read_data: got 0x%08h expected 0x%08h adr 0x%08h at %0t",
                       dat_r, sb[0].d, adr, $time);
            end
          end
          void'(sb.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    int lat;
    @(negedge clk);
    adr   = 32'hF002_0000 | 32'(off);
    dat_w = d;
    sel   = s;
    we    = w;
    cyc   = 1'b1;
    stb   = 1'b1;
    lat   = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack && lat < 8);
    rd = dat_r;
    chk("ack_latency", 32'(lat), 32'd1);
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused_rd;
    bus(1'b1, off, d, s, unused_rd);
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, off, 32'h0, 4'hF, v);
    chk(nm, v, exp);
  endtask

  // ---------------- test sequence ----------------
  int          n, k;
  logic [7:0]  roff;
  logic [31:0] rdat, rv;
  logic [3:0]  rsel;
  logic        rwe;
  logic [7:0]  reset_offs[10];

  initial begin
    n_checks = 0;
    n_errors = 0;
    adr = '0; dat_w = '0; sel = '0; we = 0; stb = 0; cyc = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values of every register
    reset_offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h80, 8'h84};
    foreach (reset_offs[j]) rd_chk("reset_read", reset_offs[j], 32'h0);
    chk("reset_intr", 32'(intr), 32'h0);

    // Periodic ch0, prescale 0: interrupt five cycles after the CTRL ack edge
    wr(8'h80, 32'h0, 4'hF);
    wr(8'h04, 32'h3, 4'hF);
    wr(8'h00, 32'h7, 4'hF);
    n = 0;
    while (!intr[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("intr0_rise_delay", 32'(n), 32'd5);
    wr(8'h0C, 32'h1, 4'hF);
    repeat (10) @(negedge clk);
    wr(8'h00, 32'h0, 4'hF);
    wr(8'h0C, 32'h1, 4'hF);
    rd_chk("ch0_flag_cleared", 8'h0C, 32'h0);

    // One-shot ch1 with prescale 9, interrupt masked
    wr(8'h80, 32'h9, 4'hF);
    wr(8'h14, 32'h2, 4'hF);
    wr(8'h10, 32'h1, 4'hF);
    repeat (40) @(negedge clk);
    rd_chk("oneshot_flag", 8'h1C, 32'h1);
    rd_chk("oneshot_en_off", 8'h10, 32'h0);
    rd_chk("oneshot_cnt_hold", 8'h18, 32'h2);
    rd_chk("oneshot_irqsum", 8'h84, 32'h0);
    chk("oneshot_intr1", 32'(intr[1]), 32'h0);

    // COUNTER load on a tick cycle wins, then counting resumes
    wr(8'h80, 32'h0, 4'hF);
    wr(8'h04, 32'h5, 4'hF);
    wr(8'h08, 32'h0, 4'hF);
    wr(8'h00, 32'h1, 4'hF);
    wr(8'h08, 32'h10, 4'hF);
    rd_chk("cnt_load_then_inc", 8'h08, 32'h11);
    wr(8'h00, 32'h0, 4'hF);

    // FLAG clear landing on a match edge: the set wins
    wr(8'h0C, 32'h1, 4'hF);
    wr(8'h04, 32'h3, 4'hF);
    wr(8'h08, 32'h0, 4'hF);
    wr(8'h00, 32'h3, 4'hF);
    repeat (2) @(negedge clk);
    wr(8'h0C, 32'h1, 4'hF);
    rd_chk("flag_set_beats_clear", 8'h0C, 32'h1);
    wr(8'h00, 32'h0, 4'hF);

    // Byte-lane write and unmapped space
    wr(8'h04, 32'h1122_3344, 4'hF);
    wr(8'h04, 32'hAABB_CCDD, 4'h1);
    rd_chk("partial_write", 8'h04, 32'h1122_33DD);
    wr(8'h30, 32'hFFFF_FFFF, 4'hF);
    rd_chk("absent_ch3_ctrl", 8'h30, 32'h0);
    rd_chk("absent_ch3_cnt", 8'h38, 32'h0);
    rd_chk("adr6_space", 8'h44, 32'h0);
    rd_chk("unmapped_glb", 8'h8C, 32'h0);

    // Randomised traffic, checked by the scoreboard
    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 9);
      if (k < 7)       roff = 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4);
      else if (k == 7) roff = 8'h80;
      else if (k == 8) roff = 8'h84;
      else             roff = 8'h44;
      rwe  = 1'($urandom_range(0, 1));
      rsel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (roff == 8'h80)                rdat = $urandom_range(0, 3);
      else if (roff[3:2] == 2'b00)      rdat = $urandom_range(0, 7);
      else if (roff[3:2] == 2'b11)      rdat = $urandom;
      else if ($urandom_range(0, 7) != 0) rdat = $urandom_range(0, 6);
      else                              rdat = $urandom;
      bus(rwe, roff, rdat, rsel, rv);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset while counting and while ack is high
    wr(8'h80, 32'h0, 4'hF);
    wr(8'h04, 32'h3, 4'hF);
    wr(8'h08, 32'h0, 4'hF);
    wr(8'h00, 32'h7, 4'hF);
    repeat (8) @(negedge clk);
    chk("pre_reset_intr0", 32'(intr[0]), 32'h1);
    @(negedge clk);
    adr = 32'hF002_0008; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ack", 32'(ack), 32'h0);
    chk("async_rst_intr", 32'(intr), 32'h0);
    chk("async_rst_dat", dat_r, 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_chk("post_rst_cnt0", 8'h08, 32'h0);
    rd_chk("post_rst_ctrl0", 8'h00, 32'h0);
    rd_chk("post_rst_cmp0", 8'h04, 32'h0);
    rd_chk("post_rst_cnt1", 8'h18, 32'h0);
    rd_chk("post_rst_prescale", 8'h80, 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
